jt900h_sdiv: RTL and testbench
==============================

# jt900h_sdiv

Parametrised multi-cycle divider for the JT900H execution unit, covering the unsigned (DIV) and signed (DIVS) forms in both full (2W/W) and half (W/(W/2)) length modes. It uses restoring division on operand magnitudes, one quotient bit per enabled clock. Sign correction and overflow detection are done inside the block. The ALU sequencer starts it with a one-cycle `start` and waits for `done`.

## Interface
- `W`, default 16: divisor/quotient/remainder width; dividend is 2W. Must be even and ≥4.
- `rst`  in  1  asynchronous reset, active-high
- `clk`  in  1  clock
- `cen`  in  1  clock enable; all state advances only on edges with cen=1
- `start`  in  1  begin operation; sampled on cen edges, ignored while busy
- `len`  in  1  1: op0[2W-1:0] / op1[W-1:0]; 0: op0[W-1:0] / op1[W/2-1:0]
- `sgn`  in  1  1: two's-complement operands and results; 0: unsigned
- `op0`  in  2W  dividend
- `op1`  in  W  divisor
- `quot`  out  W  quotient; len=0 uses [W/2-1:0] with upper half 0
- `rem`  out  W  remainder; len=0 uses [W/2-1:0] with upper half 0
- `busy`  out  1  operation in progress
- `done`  out  1  results valid; high from the completing cen edge to the next cen edge
- `v`  out  1  overflow or divide-by-zero; valid with done, held until next start

## Operation
- Reset: state IDLE. `quot`, `rem`, `busy`, `done` and `v` are all 0.
- Operands are latched at start. Later changes on op0, op1, len and sgn have no effect.
- N = W when len=1; N = W/2 when len=0. The active dividend is 2N bits and the active divisor is N bits.
- IDLE:
  - On start, go to ABS, set busy=1 and done=0.
  - Store magnitudes |D| and |d|; when sgn=0 they are the raw values.
  - Store qneg = sgn & (D_msb ^ d_msb) and rneg = sgn & D_msb.
- ABS:
  - Set v if |d|==0.
  - Set v if |D|[2N-1:N] ≥ |d|, i.e. the unsigned quotient does not fit in N bits.
  - Load the partial remainder from |D|[2N-1:N] and go to RUN.
- RUN, N cycles: standard restoring step.
  - Shift the partial remainder left by one and bring in the next dividend bit.
  - If the result ≥ |d|, subtract |d| and shift a 1 into Q; otherwise shift a 0.
  - The subtract uses an N+1-bit comparison so the carry bit is not lost.
- FIX:
  - quot = qneg ? -Q : Q and rem = rneg ? -R : R, each truncated to N bits and zero-extended to W.
  - Signed range check: if sgn and ((!qneg and Q > 2^(N-1)-1) or (qneg and Q > 2^(N-1))), set v.
  - Go to IDLE with busy=0 and done=1.
- When v=1, quot and rem values are unspecified. They must be deterministic, but the bench does not check them.
- Remainder sign follows the dividend; the quotient truncates toward zero.
- A start during busy is ignored; a new start is accepted on the first cen edge after done.

## Timing
- Latency is counted in cen edges after the edge that samples start: 1 (ABS) + N (RUN) + 1 (FIX) = N+2.
  - W=16: 18 edges for len=1, 10 edges for len=0.
- busy rises on the start edge and falls on the same edge that raises done and updates quot, rem and v.
- With cen=0, every register holds, including done.
- An asynchronous rst at any point returns to IDLE with all outputs 0 and discards the operation in flight.
- A start on the same edge that asserts done is ignored; busy is still high when that edge samples.

## Structure
- A shared package holds the state encoding (IDLE, ABS, RUN, FIX) and the iteration-count helper N(len).
- The sub-module `jt900h_div_step` is combinational. Inputs are the partial remainder, the next dividend bit and the divisor; outputs are the next remainder and the quotient bit.
- The top level holds the FSM, the bit counter, the magnitude/sign logic and the output registers.

## Test plan
- W=16, sgn=0, len=1, op0=0x000186A0, op1=7 → quot=0x37CD, rem=0x0005, v=0; done exactly 18 cen edges after start.
- sgn=1, len=1, op0=0xFFFFFFF9 (-7), op1=0x0002 → quot=0xFFFD, rem=0xFFFF, v=0.
- sgn=0, len=0, op0=0x????0064, op1=0x??07 → quot=0x000E, rem=0x0002; done after 10 edges, upper halves 0.
- Overflow cases:
  - op1=0 → v=1.
  - sgn=0, op0=0x00010000, op1=1 → v=1.
  - sgn=1, op0=0x00008000, op1=1 → v=1.
  - sgn=1, op0=0xFFFF8000, op1=1 → quot=0x8000, v=0.
- Control behaviour:
  - cen toggling 1/0 → same results in 36 clk cycles.
  - start pulsed mid-run → ignored.
  - rst asserted mid-run → busy, done, v, quot and rem all 0 immediately.
  - A fresh start after reset completes normally.

Source files
------------

// File: rtl/jt900h_sdiv_pkg.sv
// Shared definitions for the JT900H divider.
//   state_t : FSM encoding (IDLE -> ABS -> RUN -> FIX -> IDLE)
//   n_of()  : number of quotient bits produced for a given length mode
package jt900h_sdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ABS  = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Quotient width N: full length uses W bits, half length uses W/2 bits.
    function automatic int n_of(input logic len, input int w);
        return len ? w : w / 2;
    endfunction

endpackage

// File: rtl/jt900h_sdiv_if.sv
// Request/response bundle between the ALU sequencer (master) and the divider (slave).
//   cen, start, len, sgn, op0[2W], op1[W] : master -> divider
//   quot[W], rem[W], busy, done, v        : divider -> master
interface jt900h_sdiv_if #(parameter int W = 16);

    logic           cen;
    logic           start;
    logic           len;
    logic           sgn;
    logic [2*W-1:0] op0;
    logic [W-1:0]   op1;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic           busy;
    logic           done;
    logic           v;

    modport master (
        output cen, start, len, sgn, op0, op1,
        input  quot, rem, busy, done, v
    );

    modport slave (
        input  cen, start, len, sgn, op0, op1,
        output quot, rem, busy, done, v
    );

endinterface

// File: rtl/jt900h_div_step.sv
// One restoring-division step (combinational).
//   pr_i  : current partial remainder
//   bit_i : next dividend bit shifted in at the bottom
//   dv_i  : divisor magnitude
//   nr_o  : next partial remainder
//   qb_o  : quotient bit produced by this step
module jt900h_div_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] pr_i,
    input  logic         bit_i,
    input  logic [W-1:0] dv_i,
    output logic [W-1:0] nr_o,
    output logic         qb_o
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    always_comb begin
        shifted = {pr_i, bit_i};
        // The compare keeps the bit shifted out of the top so a remainder
        // that temporarily exceeds W bits is still judged correctly.
        qb_o    = (shifted >= {1'b0, dv_i});
        // When qb_o is set the true difference is below 2^W, so a W-bit
        // subtraction is exact.
        diff    = shifted[W-1:0] - dv_i;
        nr_o    = qb_o ? diff : shifted[W-1:0];
    end

endmodule

// File: rtl/jt900h_sdiv.sv
// Multi-cycle signed/unsigned divider (restoring, one quotient bit per cen edge).
//   rst : asynchronous reset, active-high
//   clk : clock
//   bus : slave side of jt900h_sdiv_if (cen/start/len/sgn/op0/op1 in,
//         quot/rem/busy/done/v out)
// Latency from the start edge to done is N+2 cen edges (N = W or W/2).
module jt900h_sdiv
    import jt900h_sdiv_pkg::*;
#(
    parameter int W = 16
) (
    input  logic              rst,
    input  logic              clk,
    jt900h_sdiv_if.slave      bus
);

    localparam int            CW        = $clog2(W + 1);
    localparam logic [W-1:0]  HALF_MASK = {{(W/2){1'b0}}, {(W/2){1'b1}}};
    localparam logic [W-1:0]  LIM_FULL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  LIM_HALF  = {{(W/2){1'b0}}, 1'b1, {(W/2-1){1'b0}}};

    state_t          state_q;
    logic [2*W-1:0]  dd_q;      // dividend magnitude
    logic [W-1:0]    dv_q;      // divisor magnitude
    logic [W-1:0]    pr_q;      // partial remainder
    logic [W-1:0]    lo_q;      // dividend bits still to shift in, MSB first
    logic [W-1:0]    q_q;       // quotient magnitude being built
    logic [CW-1:0]   cnt_q;
    logic            qneg_q, rneg_q, sgn_q, len_q, ovf_q;
    logic [W-1:0]    quot_q, rem_q;
    logic            v_q, busy_q, done_q;

    // Operand magnitude and sign capture for the start edge
    logic            d_msb, s_msb, d_neg, s_neg;
    logic [2*W-1:0]  dd_start;
    logic [W-1:0]    dv_start;

    always_comb begin
        d_msb = bus.len ? bus.op0[2*W-1] : bus.op0[W-1];
        s_msb = bus.len ? bus.op1[W-1]   : bus.op1[W/2-1];
        d_neg = bus.sgn & d_msb;
        s_neg = bus.sgn & s_msb;
        if (bus.len)
            dd_start = d_neg ? -bus.op0 : bus.op0;
        else
            dd_start = {{W{1'b0}}, (d_neg ? -bus.op0[W-1:0] : bus.op0[W-1:0])};
        if (bus.len)
            dv_start = s_neg ? -bus.op1 : bus.op1;
        else
            dv_start = {{(W/2){1'b0}}, (s_neg ? -bus.op1[W/2-1:0] : bus.op1[W/2-1:0])};
    end

    // Split of the active 2N-bit dividend into the initial remainder (upper N)
    // and the bits fed in during RUN (lower N, left-aligned in lo_q).
    logic [W-1:0] hi_init, lo_init;

    always_comb begin
        hi_init = len_q ? dd_q[2*W-1:W] : {{(W/2){1'b0}}, dd_q[W-1:W/2]};
        lo_init = len_q ? dd_q[W-1:0]   : {dd_q[W/2-1:0], {(W/2){1'b0}}};
    end

    logic [W-1:0] step_nr;
    logic         step_qb;

    jt900h_div_step #(.W(W)) u_step (
        .pr_i  (pr_q),
        .bit_i (lo_q[W-1]),
        .dv_i  (dv_q),
        .nr_o  (step_nr),
        .qb_o  (step_qb)
    );

    // Sign correction and signed range check
    logic [W-1:0] res_mask, lim, quot_fix, rem_fix;
    logic         rng_ovf;

    always_comb begin
        res_mask = len_q ? {W{1'b1}} : HALF_MASK;
        lim      = len_q ? LIM_FULL  : LIM_HALF;
        quot_fix = (qneg_q ? -q_q  : q_q)  & res_mask;
        rem_fix  = (rneg_q ? -pr_q : pr_q) & res_mask;
        // Positive results top out at 2^(N-1)-1, negative ones at -2^(N-1).
        rng_ovf  = sgn_q & ((~qneg_q & (q_q >= lim)) | (qneg_q & (q_q > lim)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dd_q    <= '0;
            dv_q    <= '0;
            pr_q    <= '0;
            lo_q    <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            sgn_q   <= 1'b0;
            len_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.cen) begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_ABS;
                        busy_q  <= 1'b1;
                        v_q     <= 1'b0;
                        dd_q    <= dd_start;
                        dv_q    <= dv_start;
                        qneg_q  <= bus.sgn & (d_msb ^ s_msb);
                        rneg_q  <= d_neg;
                        sgn_q   <= bus.sgn;
                        len_q   <= bus.len;
                    end
                end
                ST_ABS: begin
                    // Upper half >= divisor means the quotient needs more than N bits.
                    ovf_q   <= (dv_q == '0) | (hi_init >= dv_q);
                    pr_q    <= hi_init;
                    lo_q    <= lo_init;
                    q_q     <= '0;
                    cnt_q   <= CW'(n_of(len_q, W) - 1);
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    pr_q <= step_nr;
                    lo_q <= {lo_q[W-2:0], 1'b0};
                    q_q  <= {q_q[W-2:0], step_qb};
                    if (cnt_q == '0)
                        state_q <= ST_FIX;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    quot_q  <= quot_fix;
                    rem_q   <= rem_fix;
                    v_q     <= ovf_q | rng_ovf;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.v    = v_q;

endmodule

// File: tb/tb_jt900h_sdiv.sv
module tb_jt900h_sdiv;

    logic clk;
    logic rst;

    jt900h_sdiv_if #(.W(16)) bus();

    jt900h_sdiv #(.W(16)) dut (
        .rst (rst),
        .clk (clk),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        v;
        int          lat;
        int          clks;
        int          start_edge;
        int          start_clk;
    } exp_t;

    exp_t  sb[$];
    string names_q[$];

    int tests  = 0;
    int fails  = 0;
    int n_done = 0;
    int edge_cnt = 0;
    int clk_cnt  = 0;
    logic cen_tog = 1'b0;
    logic done_prev = 1'b0;

    always @(posedge clk) begin
        clk_cnt <= clk_cnt + 1;
        if (bus.cen === 1'b1)
            edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (cen_tog)
            bus.cen = ~bus.cen;
        else
            bus.cen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares each completed operation against the scoreboard head.
    always @(negedge clk) begin
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 quot=0x%0h, expected no completion", bus.quot);
            end else begin
                exp_t  e;
                string n;
                e = sb.pop_front();
                n = names_q.pop_front();
                check({n, ".v"}, 32'(bus.v), 32'(e.v));
                if (!e.v) begin
                    check({n, ".quot"}, 32'(bus.quot), 32'(e.q));
                    check({n, ".rem"},  32'(bus.rem),  32'(e.r));
                end
                check({n, ".latency"}, 32'(edge_cnt - e.start_edge), 32'(e.lat));
                if (e.clks > 0)
                    check({n, ".clk_cycles"}, 32'(clk_cnt - e.start_clk), 32'(e.clks));
                $display("[TB] %s: quot=0x%04h rem=0x%04h v=%0d lat=%0d", n, bus.quot, bus.rem, bus.v,
                         edge_cnt - e.start_edge);
                n_done <= n_done + 1;
            end
        end
        done_prev <= bus.done;
    end

    task automatic issue(input string name, input logic sgn, input logic len,
                         input logic [31:0] op0, input logic [15:0] op1,
                         input logic [15:0] eq, input logic [15:0] er, input logic ev,
                         input int lat, input int clks);
        exp_t e;
        @(negedge clk);
        bus.sgn   = sgn;
        bus.len   = len;
        bus.op0   = op0;
        bus.op1   = op1;
        bus.start = 1'b1;
        do @(posedge clk); while (bus.cen !== 1'b1);
        #1;
        e.q = eq; e.r = er; e.v = ev; e.lat = lat; e.clks = clks;
        e.start_edge = edge_cnt;
        e.start_clk  = clk_cnt;
        sb.push_back(e);
        names_q.push_back(name);
        @(negedge clk);
        bus.start = 1'b0;
        // Operands are latched; scramble them to prove later changes are ignored.
        bus.op0 = 32'hDEAD_BEEF;
        bus.op1 = 16'h0003;
        bus.sgn = ~sgn;
        bus.len = ~len;
    endtask

    task automatic wait_done(input int base, input string name);
        for (int i = 0; i < 300; i++) begin
            if (n_done > base)
                return;
            @(negedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("[TB] FAIL %s.timeout: got no done within 300 cycles, expected done", name);
        sb.delete();
        names_q.delete();
    endtask

    task automatic run_op(input string name, input logic sgn, input logic len,
                          input logic [31:0] op0, input logic [15:0] op1,
                          input logic [15:0] eq, input logic [15:0] er, input logic ev,
                          input int lat, input int clks);
        int base;
        base = n_done;
        issue(name, sgn, len, op0, op1, eq, er, ev, lat, clks);
        wait_done(base, name);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.len   = 1'b1;
        bus.op0   = '0;
        bus.op1   = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.v",    32'(bus.v),    32'd0);
        check("reset.quot", 32'(bus.quot), 32'd0);
        check("reset.rem",  32'(bus.rem),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        //        name            sgn   len   op0            op1      quot     rem      v     lat clks
        run_op("udiv_full",      1'b0, 1'b1, 32'h000186A0, 16'h0007, 16'h37CD, 16'h0005, 1'b0, 18, 0);
        run_op("sdiv_neg_pos",   1'b1, 1'b1, 32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18, 0);
        run_op("sdiv_pos_neg",   1'b1, 1'b1, 32'h00000064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 18, 0);
        run_op("udiv_half",      1'b0, 1'b0, 32'hABCD0064, 16'h5507, 16'h000E, 16'h0002, 1'b0, 10, 0);
        run_op("sdiv_half_neg",  1'b1, 1'b0, 32'h1234FF9C, 16'hAA07, 16'h00F2, 16'h00FE, 1'b0, 10, 0);
        run_op("div_by_zero",    1'b0, 1'b1, 32'h00001234, 16'h0000, 16'h0000, 16'h0000, 1'b1, 18, 0);
        run_op("udiv_ovf",       1'b0, 1'b1, 32'h00010000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 18, 0);
        run_op("sdiv_pos_ovf",   1'b1, 1'b1, 32'h00008000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 18, 0);
        run_op("sdiv_min_ok",    1'b1, 1'b1, 32'hFFFF8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18, 0);
        run_op("sdiv_half_ovf",  1'b1, 1'b0, 32'h0000FF80, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 10, 0);

        // Clock enable toggling: same result, twice the clock cycles.
        cen_tog = 1'b1;
        run_op("cen_toggle",     1'b0, 1'b1, 32'h000186A0, 16'h0007, 16'h37CD, 16'h0005, 1'b0, 18, 36);
        cen_tog = 1'b0;
        repeat (2) @(negedge clk);

        // A start pulse while busy must not disturb the running operation.
        base = n_done;
        issue("start_mid_run",   1'b0, 1'b1, 32'h000186A0, 16'h0007, 16'h37CD, 16'h0005, 1'b0, 18, 0);
        repeat (5) @(negedge clk);
        bus.op0   = 32'h00000010;
        bus.op1   = 16'h0002;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(base, "start_mid_run");
        repeat (25) @(negedge clk);
        check("start_mid_run.idle_after", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-run clears every output at once.
        issue("rst_mid_run",     1'b1, 1'b1, 32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18, 0);
        repeat (4) @(negedge clk);
        check("rst_mid_run.busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_run.busy", 32'(bus.busy), 32'd0);
        check("rst_mid_run.done", 32'(bus.done), 32'd0);
        check("rst_mid_run.v",    32'(bus.v),    32'd0);
        check("rst_mid_run.quot", 32'(bus.quot), 32'd0);
        check("rst_mid_run.rem",  32'(bus.rem),  32'd0);
        sb.delete();
        names_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op("after_reset",    1'b1, 1'b1, 32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18, 0);
        repeat (25) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
